// File: rtl/clk_phase_gen.sv
// clk_phase_gen: multi-channel programmable clock/strobe generator.
// All channels share a common time base that restarts on every ALIGN cycle.
// Each channel produces a divided clock with a programmable phase offset.
// All outputs are registered so they are free of glitches.
module clk_phase_gen #(
   parameter int NUM_CLOCKS  = 3,
   parameter int CNT_W       = 16,
   parameter int LOCK_CYCLES = 16,
   parameter int DEF_DIV     = 2,
   localparam int SEL_W      = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [SEL_W-1:0]      cfg_sel,
   input  logic [CNT_W-1:0]      cfg_div,
   input  logic [CNT_W-1:0]      cfg_phase,
   output logic [NUM_CLOCKS-1:0] outclk,
   output logic [NUM_CLOCKS-1:0] outstb,
   output logic                  locked,
   output logic                  cfg_err
);

   typedef enum logic [1:0] {ST_ALIGN, ST_SETTLE, ST_LOCKED} state_t;

   localparam int               LK_W    = $clog2(LOCK_CYCLES + 1);
   localparam logic [LK_W-1:0]  LK_LAST = LK_W'(LOCK_CYCLES - 1);
   localparam logic [SEL_W:0]   NUM_CH  = (SEL_W+1)'(NUM_CLOCKS);
   localparam logic [CNT_W-1:0] DEF_D   = CNT_W'(DEF_DIV);

   state_t                  r_state, w_state_nxt;
   logic [LK_W-1:0]         r_settle;
   logic [CNT_W-1:0]        r_div   [NUM_CLOCKS];
   logic [CNT_W-1:0]        r_phase [NUM_CLOCKS];
   logic [CNT_W-1:0]        r_pos   [NUM_CLOCKS];
   logic [CNT_W-1:0]        w_pos_nxt [NUM_CLOCKS];
   logic [NUM_CLOCKS-1:0]   r_outclk, r_outstb, w_outclk_nxt, w_outstb_nxt;
   logic                    r_locked, r_ready, r_err;
   logic                    w_locked_nxt, w_ready_nxt;
   logic                    w_accept, w_cfg_ok, w_wr_valid;

   // A write is taken only when ready; it is legal if the period is at least
   // two, the phase lies inside the period and the channel exists.
   assign w_accept   = cfg_valid & r_ready;
   assign w_cfg_ok   = (cfg_div >= CNT_W'(2)) && (cfg_phase < cfg_div) &&
                       ({1'b0, cfg_sel} < NUM_CH);
   assign w_wr_valid = w_accept & w_cfg_ok;

   // State register, settle counter, channel configuration and output registers
   always_ff @(posedge refclk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples values from before the edge regardless of order.
      if (rst) begin
         r_state  <= ST_ALIGN;
         r_settle <= '0;
         r_outclk <= '0;
         r_outstb <= '0;
         r_locked <= 1'b0;
         r_ready  <= 1'b0;
         r_err    <= 1'b0;
         // NOTE: the per-channel table is reset on purpose: the default
         // divider and zero phase are visible behaviour, not just init values.
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            r_div[i]   <= DEF_D;
            r_phase[i] <= '0;
            r_pos[i]   <= '0;
         end
      end else begin
         r_state  <= w_state_nxt;
         r_outclk <= w_outclk_nxt;
         r_outstb <= w_outstb_nxt;
         r_locked <= w_locked_nxt;
         r_ready  <= w_ready_nxt;
         if (r_state == ST_ALIGN)
            r_settle <= '0;
         else if (r_state == ST_SETTLE && r_settle != LK_LAST)
            r_settle <= r_settle + LK_W'(1);
         if (w_accept)
            r_err <= ~w_cfg_ok;
         for (int i = 0; i < NUM_CLOCKS; i++) begin
            r_pos[i] <= w_pos_nxt[i];
            if (w_wr_valid && cfg_sel == SEL_W'(i)) begin
               r_div[i]   <= cfg_div;
               r_phase[i] <= cfg_phase;
            end
         end
      end
   end

   // Next state: a valid write forces a realign, settle runs LOCK_CYCLES cycles
   always_comb begin
      // NOTE: assigning a default first keeps this block free of latches.
      w_state_nxt = r_state;
      case (r_state)
         ST_ALIGN:  w_state_nxt = ST_SETTLE;
         ST_SETTLE: begin
            if (w_wr_valid)
               w_state_nxt = ST_ALIGN;
            else if (r_settle == LK_LAST)
               w_state_nxt = ST_LOCKED;
         end
         ST_LOCKED: if (w_wr_valid) w_state_nxt = ST_ALIGN;
         default:   w_state_nxt = ST_ALIGN;
      endcase
   end

   // Output values for the next cycle; the channel position is (k - P) mod D
   always_comb begin
      w_outclk_nxt = '0;
      w_outstb_nxt = '0;
      w_locked_nxt = (w_state_nxt == ST_LOCKED);
      w_ready_nxt  = (w_state_nxt != ST_ALIGN);
      for (int i = 0; i < NUM_CLOCKS; i++) begin
         if (r_state == ST_ALIGN)
            // k = 0 follows ALIGN: position is -P folded into [0, D)
            w_pos_nxt[i] = (r_phase[i] == '0) ? '0 : r_div[i] - r_phase[i];
         else if (r_pos[i] == r_div[i] - CNT_W'(1))
            w_pos_nxt[i] = '0;
         else
            w_pos_nxt[i] = r_pos[i] + CNT_W'(1);
         if (w_state_nxt != ST_ALIGN) begin
            w_outclk_nxt[i] = (w_pos_nxt[i] < (r_div[i] >> 1));
            w_outstb_nxt[i] = (w_pos_nxt[i] == '0);
         end
      end
   end

   assign outclk    = r_outclk;
   assign outstb    = r_outstb;
   assign locked    = r_locked;
   assign cfg_ready = r_ready;
   assign cfg_err   = r_err;

endmodule

// File: tb/tb_clk_phase_gen.sv
// tb_clk_phase_gen: directed vectors, corner sequences and random traffic,
// compared against an arithmetic model of the channel timing rules.
module tb_clk_phase_gen;

   localparam int NCLK = 3;
   localparam int CW   = 16;
   localparam int LOCK = 16;
   localparam int DEFD = 2;

   logic            refclk = 1'b0;
   logic            rst = 1'b1;
   logic            cfg_valid = 1'b0;
   logic            cfg_ready;
   logic [1:0]      cfg_sel = '0;
   logic [CW-1:0]   cfg_div = '0;
   logic [CW-1:0]   cfg_phase = '0;
   logic [NCLK-1:0] outclk, outstb;
   logic            locked, cfg_err;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: m_k is the cycle index since the last ALIGN, -1 meaning ALIGN.
   int m_k = -1;
   int m_d [NCLK];
   int m_p [NCLK];
   bit m_err = 1'b0;

   clk_phase_gen #(
      .NUM_CLOCKS(NCLK), .CNT_W(CW), .LOCK_CYCLES(LOCK), .DEF_DIV(DEFD)
   ) dut (
      .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
      .outclk(outclk), .outstb(outstb), .locked(locked), .cfg_err(cfg_err)
   );

   always #5 refclk = ~refclk;

   function automatic int m_pos(int i);
      return (((m_k - m_p[i]) % m_d[i]) + m_d[i]) % m_d[i];
   endfunction

   function automatic logic [NCLK-1:0] m_clk();
      logic [NCLK-1:0] r = '0;
      for (int i = 0; i < NCLK; i++)
         r[i] = (m_k >= 0) && (m_pos(i) < m_d[i] / 2);
      return r;
   endfunction

   function automatic logic [NCLK-1:0] m_stb();
      logic [NCLK-1:0] r = '0;
      for (int i = 0; i < NCLK; i++)
         r[i] = (m_k >= 0) && (m_pos(i) == 0);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (model k=%0d, t=%0t)", name, act, exp, m_k, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit v, input int sel, input int d, input int p);
      if (r) begin
         m_k = -1;
         m_err = 1'b0;
         for (int i = 0; i < NCLK; i++) begin
            m_d[i] = DEFD;
            m_p[i] = 0;
         end
      end else if (v && m_k >= 0) begin
         if (d >= 2 && p < d && sel < NCLK) begin
            m_d[sel] = d;
            m_p[sel] = p;
            m_err = 1'b0;
            m_k = -1;
         end else begin
            m_err = 1'b1;
            m_k++;
         end
      end else begin
         m_k++;
      end
   endtask

   // One refclk cycle: drive inputs, clock, then compare on the falling edge.
   task automatic tick(input bit r, input bit v, input int sel, input int d, input int p);
      rst       = r;
      cfg_valid = v;
      cfg_sel   = sel[1:0];
      cfg_div   = d[CW-1:0];
      cfg_phase = p[CW-1:0];
      @(posedge refclk);
      model_step(r, v, sel, d, p);
      @(negedge refclk);
      check("outclk", 32'(outclk), 32'(m_clk()));
      check("outstb", 32'(outstb), 32'(m_stb()));
      check("locked", 32'(locked), 32'(m_k >= LOCK));
      check("cfg_ready", 32'(cfg_ready), 32'(m_k >= 0));
      check("cfg_err", 32'(cfg_err), 32'(m_err));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit              r;
      bit              v;
      int              sel;
      int              d;
      int              p;
      logic [NCLK-1:0] eclk;
      logic [NCLK-1:0] estb;
      bit              elock;
      bit              erdy;
      bit              eerr;
   } vec_t;

   vec_t vt[9];
   int   pat5[5];

   initial begin
      for (int i = 0; i < NCLK; i++) begin
         m_d[i] = DEFD;
         m_p[i] = 0;
      end
      pat5 = '{1, 1, 0, 0, 0};

      // Directed vectors; expected values are the state after each edge.
      vt[0] = '{1'b1, 1'b0, 0, 0, 0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0}; // reset
      vt[1] = '{1'b1, 1'b0, 0, 0, 0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0}; // ALIGN
      vt[2] = '{1'b0, 1'b0, 0, 0, 0, 3'b111, 3'b111, 1'b0, 1'b1, 1'b0}; // k=0
      vt[3] = '{1'b0, 1'b0, 0, 0, 0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0}; // k=1
      vt[4] = '{1'b0, 1'b1, 0, 1, 0, 3'b111, 3'b111, 1'b0, 1'b1, 1'b1}; // D=1 bad
      vt[5] = '{1'b0, 1'b0, 0, 0, 0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1}; // k=3
      vt[6] = '{1'b0, 1'b1, 0, 2, 1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0}; // ALIGN
      vt[7] = '{1'b0, 1'b0, 0, 0, 0, 3'b110, 3'b110, 1'b0, 1'b1, 1'b0}; // k=0
      vt[8] = '{1'b0, 1'b0, 0, 0, 0, 3'b001, 3'b001, 1'b0, 1'b1, 1'b0}; // k=1

      for (int i = 0; i < 9; i++) begin
         tick(vt[i].r, vt[i].v, vt[i].sel, vt[i].d, vt[i].p);
         check("vec_outclk", 32'(outclk), 32'(vt[i].eclk));
         check("vec_outstb", 32'(outstb), 32'(vt[i].estb));
         check("vec_locked", 32'(locked), 32'(vt[i].elock));
         check("vec_ready", 32'(cfg_ready), 32'(vt[i].erdy));
         check("vec_err", 32'(cfg_err), 32'(vt[i].eerr));
      end

      // Reset defaults: ALIGN, then toggling clocks, lock at k=16.
      tick(1, 0, 0, 0, 0);
      check("rst_align_clk", 32'(outclk), 32'd0);
      idle(1);
      check("rst_k0_clk", 32'(outclk), 32'b111);
      idle(15);
      check("rst_k15_lock", 32'(locked), 32'd0);
      idle(1);
      check("rst_k16_lock", 32'(locked), 32'd1);

      // Phase write on channel 1: D=8, P=3.
      tick(0, 1, 1, 8, 3);
      check("ph_unlock", 32'(locked), 32'd0);
      for (int k = 0; k < 16; k++) begin
         idle(1);
         check("ph_clk1", 32'(outclk[1]), 32'((k % 8) >= 3 && (k % 8) <= 6));
         check("ph_stb1", 32'(outstb[1]), 32'(k == 3 || k == 11));
         check("ph_clk0", 32'(outclk[0]), 32'(k % 2 == 0));
      end

      // Odd divider on channel 2: D=5, P=0.
      tick(0, 1, 2, 5, 0);
      for (int k = 0; k < 10; k++) begin
         idle(1);
         check("odd_clk2", 32'(outclk[2]), 32'(pat5[k % 5]));
      end

      // Invalid writes while locked, then a valid write clears the error.
      idle(8);
      check("inv_pre_lock", 32'(locked), 32'd1);
      tick(0, 1, 0, 1, 0);
      check("inv_d1_err", 32'(cfg_err), 32'd1);
      check("inv_d1_lock", 32'(locked), 32'd1);
      tick(0, 1, 0, 4, 4);
      check("inv_p_err", 32'(cfg_err), 32'd1);
      check("inv_p_lock", 32'(locked), 32'd1);
      tick(0, 1, 3, 4, 0);
      check("inv_sel_err", 32'(cfg_err), 32'd1);
      check("inv_sel_lock", 32'(locked), 32'd1);
      tick(0, 1, 0, 2, 0);
      check("inv_clear_err", 32'(cfg_err), 32'd0);

      // Back-to-back writes: the middle one lands in ALIGN and is dropped.
      idle(LOCK + 1);
      tick(0, 1, 0, 4, 1);
      check("b2b_ready0", 32'(cfg_ready), 32'd0);
      tick(0, 1, 1, 6, 2);
      check("b2b_ready1", 32'(cfg_ready), 32'd1);
      tick(0, 1, 2, 3, 0);
      check("b2b_ready2", 32'(cfg_ready), 32'd0);
      idle(LOCK);
      check("b2b_k15_lock", 32'(locked), 32'd0);
      idle(1);
      check("b2b_k16_lock", 32'(locked), 32'd1);

      // Reset at k=5 with a write presented in the same cycle.
      tick(0, 1, 1, 8, 3);
      idle(6);
      tick(1, 1, 1, 8, 3);
      check("mrst_ready", 32'(cfg_ready), 32'd0);
      idle(1);
      check("mrst_k0_clk", 32'(outclk), 32'b111);
      idle(1);
      check("mrst_k1_clk", 32'(outclk), 32'b000);
      idle(15);
      check("mrst_k16_lock", 32'(locked), 32'd1);

      // Largest divider: D=2^16-1, P=D-1, run through one full wrap.
      tick(0, 1, 0, 65535, 65534);
      idle(65535);
      check("big_k65534_stb", 32'(outstb[0]), 32'd1);
      idle(3);

      // Random traffic against the model.
      for (int i = 0; i < 800; i++)
         tick($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 9));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_phase_gen.md
CLK_PHASE_GEN -- requirements
Module: clk_phase_gen

Interface
REQ-001 Parameter NUM_CLOCKS, default 3: number of generated clock channels, range 1..18.
REQ-002 Parameter CNT_W, default 16: width of the divider and phase fields.
REQ-003 Parameter LOCK_CYCLES, default 16: settle cycles before locked asserts, minimum 1.
REQ-004 Parameter DEF_DIV, default 2: per-channel divider loaded at reset, minimum 2.
REQ-005 Port refclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port cfg_valid, input, 1 bit: configuration write request.
REQ-008 Port cfg_ready, output, 1 bit: the block can accept a configuration write.
REQ-009 Port cfg_sel, input, max(1,clog2(NUM_CLOCKS)) bits: target channel index.
REQ-010 Port cfg_div, input, CNT_W bits: channel period D, in refclk cycles.
REQ-011 Port cfg_phase, input, CNT_W bits: channel phase offset P, in refclk cycles.
REQ-012 Port outclk, output, NUM_CLOCKS bits: generated clocks; bit i is channel i.
REQ-013 Port outstb, output, NUM_CLOCKS bits: one-cycle strobe marking each outclk rising edge.
REQ-014 Port locked, output, 1 bit: every channel is aligned and has settled.
REQ-015 Port cfg_err, output, 1 bit: the last accepted configuration write was invalid.

Function
REQ-016 State machine: ALIGN, SETTLE, LOCKED.
- ALIGN lasts exactly one cycle, then goes to SETTLE.
- SETTLE goes to LOCKED after LOCK_CYCLES cycles.
REQ-017 cfg_ready SHALL be 1 in SETTLE and LOCKED, and 0 in ALIGN and during rst.
REQ-018 A write is accepted on a cycle where cfg_valid=1 and cfg_ready=1.
REQ-019 An accepted write is valid if all of these hold: D>=2, P<D, cfg_sel<NUM_CLOCKS.
REQ-020 Valid write:
- store D and P for the selected channel;
- clear cfg_err;
- enter ALIGN on the next cycle, with locked=0 from that cycle onward.
REQ-021 Invalid write:
- set cfg_err=1 on the next cycle;
- leave the stored configuration and the state unchanged;
- locked is unaffected.
REQ-022 Cycle numbering: cycle k=0 is the first SETTLE cycle after an ALIGN; k counts up every refclk cycle.
REQ-023 In SETTLE and LOCKED, outclk[i] SHALL be 1 exactly when ((k-P_i) mod D_i) < floor(D_i/2).
REQ-024 In SETTLE and LOCKED, outstb[i] SHALL be 1 exactly when ((k-P_i) mod D_i) == 0.
REQ-025 In ALIGN, outclk and outstb SHALL be 0.
REQ-026 All channels SHALL realign together on every ALIGN, including channels whose configuration did not change.
REQ-027 locked SHALL be 1 for all k>=LOCK_CYCLES while no ALIGN occurs, and 0 otherwise.
REQ-028 Counters wrap modulo D_i with no drift, indefinitely; behaviour at D_i = 2^CNT_W-1 is exact.
REQ-029 Outputs change only on rising refclk edges and are glitch-free (registered).
REQ-030 rst asserted mid-operation SHALL abort any state, discard any write presented in that cycle, and apply REQ-031.

Reset
REQ-031 While rst=1, the block SHALL hold:
- outputs: outclk=0, outstb=0, locked=0, cfg_ready=0, cfg_err=0;
- every channel: D=DEF_DIV, P=0;
- state: ALIGN.
REQ-032 The first cycle after rst falls is the ALIGN cycle; k=0 is the following cycle.

Verification
REQ-033 Reset defaults (defaults, DEF_DIV=2): release rst ->
- ALIGN for 1 cycle, then all outclk toggle 1,0,1,0 starting at k=0;
- outstb=1 at every even k;
- locked=1 at k=16.
REQ-034 Phase write: write ch1 D=8 P=3 while LOCKED ->
- locked=0 the next cycle;
- outclk[1] high for k=3..6, 11..14, ...;
- outstb[1] at k=3,11,...;
- ch0 and ch2 restart at k=0.
REQ-035 Odd divider: write ch2 D=5 P=0 -> outclk[2] pattern 1,1,0,0,0 repeating (floor(5/2)=2 high cycles).
REQ-036 Invalid writes: write D=1, then a separate write D=4 P=4, then cfg_sel=3 ->
- cfg_err=1 after each;
- locked stays 1 and outputs stay unchanged;
- a following valid write clears cfg_err.
REQ-037 Back-to-back writes: hold cfg_valid=1 for 3 cycles while LOCKED ->
- writes are accepted only on cycles where cfg_ready=1 (never in ALIGN);
- locked is reached LOCK_CYCLES after the final ALIGN.
REQ-038 Reset mid-settle: assert rst at k=5 with a write presented in the same cycle ->
- the write is discarded and all configuration returns to D=2, P=0;
- the sequence of REQ-033 repeats.
